// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for pipeline-boundary buffers.
//   occ_t             : occupancy encoding (EMPTY / ONE / TWO)
//   RESET_PAYLOAD_BIT : fill bit for reset/invalid payloads (all zeros);
//                       replicate it to the payload width at the use site.
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  localparam logic RESET_PAYLOAD_BIT = 1'b0;

endpackage : pipe_pkg

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
// Ports:
//   clk : clock, counter updates on rising edge
//   clr : synchronous clear (wins over inc)
//   inc : increment enable; ignored once the counter is at all-ones
//   cnt : current count, sticks at 2^W-1
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_r;

  // Count register: clear, saturating increment, otherwise hold.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_r <= {W{1'b0}};
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule : sat_counter

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: pipeline-boundary buffer with valid/ready on both sides,
// multi-source stall, flush (priority over stall) and a saturating stall
// cycle counter.
//
// Build option: PIPE_STAGE_SKID_EN
//   defined   : two entries (head + skid); in_ready does not depend on
//               out_ready, only on occupancy, stall and flush.
//   undefined : single entry; in_ready = (empty | out_ready) & ~stall & ~flush.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   stall_in[N_STALL] : stall requests, OR-ed together
//   flush             : discard buffered entries
//   in_valid/in_ready/in_data    : upstream handshake and payload
//   out_valid/out_ready/out_data : downstream handshake and head payload
//   occ               : occupancy 0..2
//   stall_cnt         : saturating count of stalled cycles (cleared by rst only)
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned N_STALL = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_STALL-1:0] stall_in,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [1:0]         occ,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic [DATA_W-1:0] ZERO_PAYLOAD = {DATA_W{RESET_PAYLOAD_BIT}};

  logic              stall_s;
  logic              enq_s;
  logic              deq_s;
  occ_t              occ_r;
  logic [DATA_W-1:0] head_r;
`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_r;
`endif

  // Handshake decode; rst also masks both sides so the reset cycle
  // neither accepts nor presents data.
  always_comb begin
    stall_s = |stall_in;
`ifdef PIPE_STAGE_SKID_EN
    in_ready = (occ_r != OCC_TWO) & ~stall_s & ~flush & ~rst;
`else
    in_ready = ((occ_r == OCC_EMPTY) | out_ready) & ~stall_s & ~flush & ~rst;
`endif
    out_valid = (occ_r != OCC_EMPTY) & ~stall_s & ~flush & ~rst;
    enq_s     = in_valid & in_ready;
    deq_s     = out_valid & out_ready;
  end

  // Occupancy FSM and payload storage. Empty slots are forced to zero so
  // stale data never lingers behind an invalid entry.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ_r  <= OCC_EMPTY;
      head_r <= ZERO_PAYLOAD;
`ifdef PIPE_STAGE_SKID_EN
      skid_r <= ZERO_PAYLOAD;
`endif
    end else if (stall_s) begin
      occ_r  <= occ_r;
      head_r <= head_r;
`ifdef PIPE_STAGE_SKID_EN
      skid_r <= skid_r;
`endif
    end else begin
      case (occ_r)
        OCC_EMPTY: begin
          if (enq_s) begin
            head_r <= in_data;
            occ_r  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (enq_s && deq_s) begin
            head_r <= in_data;
          end else if (deq_s) begin
            head_r <= ZERO_PAYLOAD;
            occ_r  <= OCC_EMPTY;
`ifdef PIPE_STAGE_SKID_EN
          end else if (enq_s) begin
            skid_r <= in_data;
            occ_r  <= OCC_TWO;
`endif
          end
        end
        OCC_TWO: begin
`ifdef PIPE_STAGE_SKID_EN
          // in_ready is low here, so only a dequeue can happen.
          if (deq_s) begin
            head_r <= skid_r;
            skid_r <= ZERO_PAYLOAD;
            occ_r  <= OCC_ONE;
          end
`else
          // Unreachable in the single-entry build; recover to empty.
          head_r <= ZERO_PAYLOAD;
          occ_r  <= OCC_EMPTY;
`endif
        end
        default: begin
          head_r <= ZERO_PAYLOAD;
`ifdef PIPE_STAGE_SKID_EN
          skid_r <= ZERO_PAYLOAD;
`endif
          occ_r  <= OCC_EMPTY;
        end
      endcase
    end
  end

  assign out_data = head_r;
  assign occ      = occ_r;

  // Stall statistics: counts stalled cycles, flush does not clear it.
  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (stall_s & ~rst),
    .cnt (stall_cnt)
  );

endmodule : pipe_stage_buf

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed self-checking bench for pipe_stage_buf.
// Uses CNT_W=4 so counter saturation is reachable quickly. Covers both the
// single-entry build and the PIPE_STAGE_SKID_EN build.
module tb_pipe_stage_buf;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned N_STALL = 3;
  localparam int unsigned CNT_W   = 4;

  logic               clk;
  logic               rst;
  logic [N_STALL-1:0] stall_in;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [1:0]         occ;
  logic [CNT_W-1:0]   stall_cnt;

  int n_tests;
  int n_fail;

  localparam logic [63:0] W0 = 64'h0000_0004_0000_0013;
  localparam logic [63:0] A  = 64'h0000_0000_0000_00AA;
  localparam logic [63:0] B  = 64'h0000_0000_0000_00BB;
  localparam logic [63:0] C  = 64'h0000_0000_0000_00CC;
  localparam logic [63:0] E  = 64'h0000_0000_0000_00EE;

  pipe_stage_buf #(
    .DATA_W  (DATA_W),
    .N_STALL (N_STALL),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall_in  (stall_in),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occ       (occ),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    stall_in  = 3'b000;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = C;
    out_ready = 1'b1;

    // ---------------- reset ----------------
    tick();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_occ", {62'd0, occ}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_stall_cnt", {60'd0, stall_cnt}, 64'd0);
    chk("rst_in_ready_after", {63'd0, in_ready}, 64'd1);

    // ---------------- streaming ----------------
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'b1;
      in_data   = W0 + 64'(i);
      out_ready = 1'b1;
      #1;
      chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
      tick();
      chk("stream_out_valid", {63'd0, out_valid}, 64'd1);
      chk("stream_out_data", out_data, W0 + 64'(i));
      chk("stream_occ", {62'd0, occ}, 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain_occ", {62'd0, occ}, 64'd0);
    chk("stream_drain_data", out_data, 64'd0);
    chk("stream_drain_valid", {63'd0, out_valid}, 64'd0);

    // ---------------- backpressure ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = A;
    tick();
    chk("bp_occ_a", {62'd0, occ}, 64'd1);
    chk("bp_head_a", out_data, A);
    in_data = B;
    #1;
`ifdef PIPE_STAGE_SKID_EN
    chk("bp_skid_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("bp_occ2", {62'd0, occ}, 64'd2);
    chk("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_full_head", out_data, A);
    out_ready = 1'b1;
    #1;
    chk("bp_deliver_a_valid", {63'd0, out_valid}, 64'd1);
    tick();
    chk("bp_deliver_b", out_data, B);
    chk("bp_occ_after_a", {62'd0, occ}, 64'd1);
`else
    chk("bp_refuse_b", {63'd0, in_ready}, 64'd0);
    tick();
    chk("bp_held_a", out_data, A);
    chk("bp_occ_hold", {62'd0, occ}, 64'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_deliver_a_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_pass_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("bp_deliver_b", out_data, B);
    chk("bp_occ_after_a", {62'd0, occ}, 64'd1);
`endif
    tick();
    chk("bp_drain_occ", {62'd0, occ}, 64'd0);

    // ---------------- flush priority ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = A;
    tick();
`ifdef PIPE_STAGE_SKID_EN
    in_data = B;
    tick();
    chk("fl_pre_occ", {62'd0, occ}, 64'd2);
`else
    chk("fl_pre_occ", {62'd0, occ}, 64'd1);
`endif
    flush     = 1'b1;
    stall_in  = 3'b001;
    in_data   = C;
    out_ready = 1'b1;
    #1;
    chk("fl_in_ready", {63'd0, in_ready}, 64'd0);
    chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
    tick();
    flush    = 1'b0;
    stall_in = 3'b000;
    in_valid = 1'b0;
    #1;
    chk("fl_occ", {62'd0, occ}, 64'd0);
    chk("fl_out_valid_after", {63'd0, out_valid}, 64'd0);
    chk("fl_out_data", out_data, 64'd0);
    chk("fl_stall_cnt", {60'd0, stall_cnt}, 64'd1);

    // ---------------- stall hold ----------------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("sh_cnt_cleared", {60'd0, stall_cnt}, 64'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hDEAD;
    tick();
    chk("sh_head", out_data, 64'hDEAD);
    stall_in  = 3'b010;
    out_ready = 1'b1;
    in_data   = 64'hBEEF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("sh_out_valid", {63'd0, out_valid}, 64'd0);
      chk("sh_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
      chk("sh_out_data", out_data, 64'hDEAD);
      chk("sh_occ", {62'd0, occ}, 64'd1);
    end
    chk("sh_stall_cnt", {60'd0, stall_cnt}, 64'd5);
    stall_in = 3'b000;
    in_valid = 1'b0;
    #1;
    chk("sh_release_valid", {63'd0, out_valid}, 64'd1);
    chk("sh_release_data", out_data, 64'hDEAD);
    tick();
    chk("sh_release_occ", {62'd0, occ}, 64'd0);
    chk("sh_cnt_after", {60'd0, stall_cnt}, 64'd5);

    // ---------------- counter saturation ----------------
    stall_in = 3'b100;
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    chk("sat_cnt", {60'd0, stall_cnt}, 64'd15);
    tick();
    chk("sat_cnt_hold", {60'd0, stall_cnt}, 64'd15);
    stall_in = 3'b000;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    chk("sat_after_flush", {60'd0, stall_cnt}, 64'd15);

    // ---------------- reset mid-operation ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = A;
    tick();
`ifdef PIPE_STAGE_SKID_EN
    in_data = B;
    tick();
    chk("rm_pre_occ", {62'd0, occ}, 64'd2);
`else
    chk("rm_pre_occ", {62'd0, occ}, 64'd1);
`endif
    in_valid = 1'b0;
    stall_in = 3'b001;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    stall_in = 3'b000;
    #1;
    chk("rm_occ", {62'd0, occ}, 64'd0);
    chk("rm_out_data", out_data, 64'd0);
    chk("rm_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rm_stall_cnt", {60'd0, stall_cnt}, 64'd0);
    in_valid  = 1'b1;
    in_data   = E;
    out_ready = 1'b1;
    #1;
    chk("rm_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("rm_push_valid", {63'd0, out_valid}, 64'd1);
    chk("rm_push_data", out_data, E);
    tick();
    chk("rm_push_drain", {62'd0, occ}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net: never hang if something above stalls the process.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule : tb_pipe_stage_buf
